// File: rtl/eh2_dec_trigger_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module : eh2_dec_trigger_chain_pkg
// Brief  : Types and helpers shared by the decode-stage trigger chain unit.
// Rev    : 1.0  initial release
// ============================================================================
package eh2_dec_trigger_chain_pkg;

    typedef struct packed {
        logic        select;
        logic        match;
        logic        execute;
        logic        m;
        logic        chain;
        logic        count_en;
        logic [31:0] tdata2;
    } eh2_trigger_chain_pkt_t;

    // Masked compare: with masken, the trailing ones of mask and the bit just
    // above them are don't-care (NAPOT range); otherwise exact compare.
    function automatic logic rvmaskandmatch(input logic [31:0] mask,
                                            input logic [31:0] data,
                                            input logic        masken);
        logic [31:0] v_hit;
        logic        v_ones;
        v_hit[0] = masken | (mask[0] == data[0]);
        v_ones   = mask[0];
        for (int i = 1; i < 32; i++) begin
            v_hit[i] = (masken & v_ones) | (mask[i] == data[i]);
            v_ones   = v_ones & mask[i];
        end
        return &v_hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eh2_dec_trigger_chain_slot.sv
`default_nettype none
// ============================================================================
// Module : eh2_dec_trigger_slot
// Brief  : One issue slot: raw match, count/chain gating and next state.
// Rev    : 1.0  initial release
// ============================================================================
module eh2_dec_trigger_slot
    import eh2_dec_trigger_chain_pkg::*;
#(
    parameter int NUM_TRIG = 4,
    parameter int CNT_W    = 16
) (
    input  logic                                valid,
    input  logic [31:1]                         pc,
    input  eh2_trigger_chain_pkt_t [NUM_TRIG-1:0] pkt,
    input  logic [NUM_TRIG-1:0][CNT_W-1:0]      cnt_in,
    input  logic [NUM_TRIG-1:0]                 armed_in,
    output logic [NUM_TRIG-1:0]                 fire,
    output logic [NUM_TRIG-1:0][CNT_W-1:0]      cnt_out,
    output logic [NUM_TRIG-1:0]                 armed_out
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [NUM_TRIG-1:0] w_raw;
    logic [NUM_TRIG-1:0] w_cgate;
    logic [NUM_TRIG-1:0] w_agate;
    logic [NUM_TRIG-1:0] w_dec;
    logic                w_unused_chain0;

    assign w_unused_chain0 = pkt[0].chain;

    for (genvar i = 0; i < NUM_TRIG; i++) begin : g_trig
        assign w_raw[i]   = valid & pkt[i].execute & pkt[i].m & ~pkt[i].select &
                            rvmaskandmatch(pkt[i].tdata2, {pc, pkt[i].tdata2[0]}, pkt[i].match);
        assign w_cgate[i] = ~pkt[i].count_en | (cnt_in[i] == c_cnt_one);
        assign fire[i]    = w_raw[i] & w_cgate[i] & w_agate[i];
        // A parked counter (0) never moves; 1 only moves when it actually fires.
        assign w_dec[i]   = w_raw[i] & pkt[i].count_en & ((cnt_in[i] > c_cnt_one) | fire[i]);
        assign cnt_out[i] = w_dec[i] ? (cnt_in[i] - c_cnt_one) : cnt_in[i];

        if (i == 0) begin : g_head
            assign w_agate[i]   = 1'b1;
            assign armed_out[i] = armed_in[i] & ~fire[i];
        end else begin : g_link
            assign w_agate[i]   = ~pkt[i].chain | armed_in[i];
            // Arming by the predecessor takes precedence over self-clear.
            assign armed_out[i] = (armed_in[i] & ~fire[i]) | (fire[i-1] & pkt[i].chain);
        end
    end

endmodule
`default_nettype wire

// File: rtl/eh2_dec_trigger_chain.sv
`default_nettype none
// ============================================================================
// Module : eh2_dec_trigger_chain
// Brief  : Decode-stage PC triggers with hit counting and sequential chaining.
// Rev    : 1.0  initial release
// ============================================================================
module eh2_dec_trigger_chain
    import eh2_dec_trigger_chain_pkg::*;
#(
    parameter int NUM_THREADS = 2,
    parameter int NUM_TRIG    = 4,
    parameter int CNT_W       = 16
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  eh2_trigger_chain_pkt_t [NUM_THREADS-1:0][NUM_TRIG-1:0] trigger_pkt_any,
    input  logic [NUM_THREADS-1:0][NUM_TRIG-1:0]              cfg_wr,
    input  logic [CNT_W-1:0]                                  cfg_count,
    input  logic [31:1]                                       dec_i0_pc_d,
    input  logic [31:1]                                       dec_i1_pc_d,
    input  logic                                              dec_i0_tid_d,
    input  logic                                              dec_i1_tid_d,
    input  logic                                              dec_i0_valid_d,
    input  logic                                              dec_i1_valid_d,
    input  logic                                              dec_stall_d,
    input  logic [NUM_THREADS-1:0]                            dec_tlu_flush_lower,
    output logic [NUM_TRIG-1:0]                               dec_i0_trigger_match_d,
    output logic [NUM_TRIG-1:0]                               dec_i1_trigger_match_d,
    output logic [NUM_THREADS-1:0][NUM_TRIG-1:0]              trig_armed,
    output logic [NUM_THREADS-1:0][NUM_TRIG-1:0][CNT_W-1:0]   trig_count
);

    logic [NUM_THREADS-1:0][NUM_TRIG-1:0][CNT_W-1:0] r_cnt;
    logic [NUM_THREADS-1:0][NUM_TRIG-1:0]            r_armed;
    logic [NUM_THREADS-1:0][NUM_TRIG-1:0][CNT_W-1:0] w_nxt_cnt;
    logic [NUM_THREADS-1:0][NUM_TRIG-1:0]            w_nxt_armed;

    logic [NUM_TRIG-1:0][CNT_W-1:0] w_i0_cnt_nxt, w_i1_cnt, w_i1_cnt_nxt;
    logic [NUM_TRIG-1:0]            w_i0_armed_nxt, w_i1_armed, w_i1_armed_nxt;
    logic                           w_same_tid;

    assign w_same_tid = (dec_i0_tid_d == dec_i1_tid_d);
    // i1 is younger: on a shared thread it must observe i0's effect.
    assign w_i1_cnt   = w_same_tid ? w_i0_cnt_nxt   : r_cnt[dec_i1_tid_d];
    assign w_i1_armed = w_same_tid ? w_i0_armed_nxt : r_armed[dec_i1_tid_d];

    eh2_dec_trigger_slot #(.NUM_TRIG(NUM_TRIG), .CNT_W(CNT_W)) u_slot_i0 (
        .valid     (dec_i0_valid_d),
        .pc        (dec_i0_pc_d),
        .pkt       (trigger_pkt_any[dec_i0_tid_d]),
        .cnt_in    (r_cnt[dec_i0_tid_d]),
        .armed_in  (r_armed[dec_i0_tid_d]),
        .fire      (dec_i0_trigger_match_d),
        .cnt_out   (w_i0_cnt_nxt),
        .armed_out (w_i0_armed_nxt)
    );

    eh2_dec_trigger_slot #(.NUM_TRIG(NUM_TRIG), .CNT_W(CNT_W)) u_slot_i1 (
        .valid     (dec_i1_valid_d),
        .pc        (dec_i1_pc_d),
        .pkt       (trigger_pkt_any[dec_i1_tid_d]),
        .cnt_in    (w_i1_cnt),
        .armed_in  (w_i1_armed),
        .fire      (dec_i1_trigger_match_d),
        .cnt_out   (w_i1_cnt_nxt),
        .armed_out (w_i1_armed_nxt)
    );

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
        assign w_nxt_cnt[t]   = (dec_i1_tid_d == 1'(t)) ? w_i1_cnt_nxt :
                                (dec_i0_tid_d == 1'(t)) ? w_i0_cnt_nxt : r_cnt[t];
        assign w_nxt_armed[t] = (dec_i1_tid_d == 1'(t)) ? w_i1_armed_nxt :
                                (dec_i0_tid_d == 1'(t)) ? w_i0_armed_nxt : r_armed[t];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_armed <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                for (int i = 0; i < NUM_TRIG; i++) begin
                    if (cfg_wr[t][i]) begin
                        r_cnt[t][i]   <= cfg_count;
                        r_armed[t][i] <= 1'b0;
                    end else if (dec_tlu_flush_lower[t]) begin
                        r_armed[t][i] <= 1'b0;
                    end else if (!dec_stall_d) begin
                        r_cnt[t][i]   <= w_nxt_cnt[t][i];
                        r_armed[t][i] <= w_nxt_armed[t][i];
                    end
                end
            end
        end
    end

    assign trig_armed = r_armed;
    assign trig_count = r_cnt;

endmodule
`default_nettype wire
